// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, PS/2 set-2 scan codes and the keypad decode table.
package calc_pkg;

    localparam int unsigned KEY_W  = 11;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned BYTE_W = 8;

    localparam logic [CODE_W-1:0] KEY_PLUS  = 4'd10;
    localparam logic [CODE_W-1:0] KEY_MINUS = 4'd11;
    localparam logic [CODE_W-1:0] KEY_MUL   = 4'd12;
    localparam logic [CODE_W-1:0] KEY_DIV   = 4'd13;
    localparam logic [CODE_W-1:0] KEY_ENTER = 4'd14;

    localparam logic [BYTE_W-1:0] SC_0     = 8'h70;
    localparam logic [BYTE_W-1:0] SC_1     = 8'h69;
    localparam logic [BYTE_W-1:0] SC_2     = 8'h72;
    localparam logic [BYTE_W-1:0] SC_3     = 8'h7A;
    localparam logic [BYTE_W-1:0] SC_4     = 8'h6B;
    localparam logic [BYTE_W-1:0] SC_5     = 8'h73;
    localparam logic [BYTE_W-1:0] SC_6     = 8'h74;
    localparam logic [BYTE_W-1:0] SC_7     = 8'h6C;
    localparam logic [BYTE_W-1:0] SC_8     = 8'h75;
    localparam logic [BYTE_W-1:0] SC_9     = 8'h7D;
    localparam logic [BYTE_W-1:0] SC_PLUS  = 8'h79;
    localparam logic [BYTE_W-1:0] SC_MINUS = 8'h7B;
    localparam logic [BYTE_W-1:0] SC_MUL   = 8'h7C;
    localparam logic [BYTE_W-1:0] SC_DIV   = 8'h4A;
    localparam logic [BYTE_W-1:0] SC_ENTER = 8'h5A;
    localparam logic [BYTE_W-1:0] SC_EXT   = 8'hE0;
    localparam logic [BYTE_W-1:0] SC_BRK   = 8'hF0;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    typedef struct packed {
        logic              hit;
        logic [CODE_W-1:0] code;
    } key_dec_t;

    // Keypad scan code to key code; divide only exists behind the E0 prefix.
    function automatic key_dec_t decode_scan(input logic [BYTE_W-1:0] sc, input logic ext);
        key_dec_t d;
        d.hit  = 1'b1;
        d.code = '0;
        case (sc)
            SC_0:     d.code = 4'd0;
            SC_1:     d.code = 4'd1;
            SC_2:     d.code = 4'd2;
            SC_3:     d.code = 4'd3;
            SC_4:     d.code = 4'd4;
            SC_5:     d.code = 4'd5;
            SC_6:     d.code = 4'd6;
            SC_7:     d.code = 4'd7;
            SC_8:     d.code = 4'd8;
            SC_9:     d.code = 4'd9;
            SC_PLUS:  d.code = KEY_PLUS;
            SC_MINUS: d.code = KEY_MINUS;
            SC_MUL:   d.code = KEY_MUL;
            SC_ENTER: d.code = KEY_ENTER;
            SC_DIV: begin
                d.hit  = ext;
                d.code = KEY_DIV;
            end
            default:  d.hit = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ps2_keypad_if.sv
// PS/2 line inputs and calculator key outputs of the keypad front end.
interface ps2_keypad_if;
    import calc_pkg::*;

    logic             ps2_clk;
    logic             ps2_data;
    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             frame_err;

    modport master (input ps2_clk, input ps2_data, output key_code, output key_valid, output frame_err);
    modport slave  (output ps2_clk, output ps2_data, input key_code, input key_valid, input frame_err);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: line synchronizers, clock deglitch filter, frame FSM and inter-edge timeout.
module ps2_rx
    import calc_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic [BYTE_W-1:0] rx_byte_c,
    output logic              byte_valid_c,
    output logic              err_c
);
    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);

    logic              clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic              dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic              filt_q, filt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    rx_state_e         state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              fall_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            filt_q    <= 1'b1;
            fcnt_q    <= '0;
            state_q   <= RX_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            clk_s1_q  <= clk_s1_d;
            clk_s2_q  <= clk_s2_d;
            dat_s1_q  <= dat_s1_d;
            dat_s2_q  <= dat_s2_d;
            filt_q    <= filt_d;
            fcnt_q    <= fcnt_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        clk_s1_d = ps2_clk;
        clk_s2_d = clk_s1_q;
        dat_s1_d = ps2_data;
        dat_s2_d = dat_s1_q;
        filt_d   = filt_q;
        fcnt_d   = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) filt_d = clk_s2_q;
            else                                  fcnt_d = fcnt_q + FCNT_W'(1);
        end
        fall_c = filt_q & ~filt_d;
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        to_cnt_d     = '0;
        byte_valid_c = 1'b0;
        err_c        = 1'b0;
        rx_byte_c    = shift_q;
        if (state_q != RX_IDLE && !fall_c) to_cnt_d = to_cnt_q + TO_W'(1);

        if (state_q != RX_IDLE && !fall_c && to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
            state_d  = RX_IDLE;
            to_cnt_d = '0;
            err_c    = 1'b1;
        end else if (fall_c) begin
            case (state_q)
                RX_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                        par_d     = 1'b0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[BYTE_W-1:1]};
                    par_d     = par_q ^ dat_s2_q;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    par_d   = par_q ^ dat_s2_q;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (dat_s2_q && par_q) byte_valid_c = 1'b1;
                    else                   err_c        = 1'b1;
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/ps2_keypad.sv
// PS/2 keyboard to calculator keypad: prefix tracking, key decode and typematic suppression.
module ps2_keypad
    import calc_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_keypad_if.master  bus
);
    logic [BYTE_W-1:0] rx_byte_c;
    logic              byte_valid_c, err_c;
    key_dec_t          dec_c;
    logic              same_c;

    logic              ext_q, ext_d, brk_q, brk_d, lock_q, lock_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d, frame_err_q, frame_err_d;

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (bus.ps2_clk),
        .ps2_data     (bus.ps2_data),
        .rx_byte_c    (rx_byte_c),
        .byte_valid_c (byte_valid_c),
        .err_c        (err_c)
    );

    assign dec_c  = decode_scan(rx_byte_c, ext_q);
    // key_code_q doubles as the last emitted code for the typematic lock.
    assign same_c = lock_q && (key_code_q == dec_c.code);

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            lock_q      <= 1'b0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            lock_q      <= lock_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        lock_d      = lock_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;
        if (err_c) begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end else if (byte_valid_c) begin
            if (rx_byte_c == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte_c == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (dec_c.hit) begin
                    if (brk_q) begin
                        if (same_c) lock_d = 1'b0;
                    end else if (!same_c) begin
                        key_valid_d = 1'b1;
                        key_code_d  = dec_c.code;
                        lock_d      = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.key_code  = KEY_W'(key_code_q);
    assign bus.key_valid = key_valid_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_keypad.sv
// Self-checking bench for ps2_keypad: directed scenarios plus a randomized byte stream against a scan-code model.
module tb_ps2_keypad;
    localparam int unsigned FL = 4;
    localparam int unsigned TO = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_keypad_if bus ();
    ps2_keypad #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Observed output events
    int          cyc = 0;
    int          got_code[$];
    int          got_cyc[$];
    int          got_err = 0;
    int          viol = 0;
    logic [10:0] prev_code = '0;
    int          last_stop_cyc = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (bus.key_valid) begin
                got_code.push_back(int'(bus.key_code));
                got_cyc.push_back(cyc);
            end
            if (bus.frame_err) got_err = got_err + 1;
            if (bus.key_valid && bus.frame_err) viol = viol + 1;
            if (!bus.key_valid && bus.key_code !== prev_code) viol = viol + 1;
            if (bus.key_code[10:4] !== 7'd0) viol = viol + 1;
        end
        prev_code = bus.key_code;
    end

    // Reference model: scan-code table indexed by key code
    int sc_tab[15] = '{'h70, 'h69, 'h72, 'h7A, 'h6B, 'h73, 'h74, 'h6C, 'h75, 'h7D,
                       'h79, 'h7B, 'h7C, 'h4A, 'h5A};
    bit m_ext = 0, m_brk = 0, m_lock = 0;
    int m_last = 0;
    int exp_code[$];
    int exp_err = 0;

    function automatic int ref_key(input logic [7:0] b, input bit ext);
        for (int k = 0; k < 15; k++)
            if (sc_tab[k] == int'(b) && (k != 13 || ext)) return k;
        return -1;
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit bad);
        int k;
        if (bad) begin
            exp_err++; m_ext = 0; m_brk = 0;
            return;
        end
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            k = ref_key(b, m_ext);
            if (k >= 0) begin
                if (m_brk) begin
                    if (m_lock && m_last == k) m_lock = 0;
                end else if (!(m_lock && m_last == k)) begin
                    exp_code.push_back(k); m_last = k; m_lock = 1;
                end
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_lock = 0; m_last = 0;
    endtask

    task automatic clear();
        got_code.delete(); got_cyc.delete(); got_err = 0;
        exp_code.delete(); exp_err = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // One PS/2 bit: data set while clock high, then a 16-cycle low phase.
    task automatic drive_bit(input logic v, input bit glitch, output int fall_cyc);
        bus.ps2_data = v;
        if (glitch) begin
            tick(1); bus.ps2_clk = 1'b0; tick(1); bus.ps2_clk = 1'b1; tick(2);
        end else tick(4);
        bus.ps2_clk = 1'b0;
        fall_cyc = cyc;
        if (glitch) begin
            tick(8); bus.ps2_clk = 1'b1; tick(1); bus.ps2_clk = 1'b0; tick(7);
        end else tick(16);
        bus.ps2_clk = 1'b1;
        tick(4);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit glitch);
        logic [10:0] fr;
        int fc;
        fr[0]   = 1'b0;
        fr[8:1] = b;
        fr[9]   = ~(^b) ^ bad_par;
        fr[10]  = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            drive_bit(fr[i], glitch, fc);
            if (i == 10) last_stop_cyc = fc;
        end
        bus.ps2_data = 1'b1;
        tick(8);
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0,
                         input bit glitch = 0);
        send_frame(b, bad_par, bad_stop, 11, glitch);
        model_frame(b, bad_par | bad_stop);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.ps2_clk = 1'b1; bus.ps2_data = 1'b1;
        tick(5);
        n_cmp++; if (bus.key_code !== 11'd0) begin n_bad++; $display("FAIL reset_key_code got %0d want 0", bus.key_code); end
        n_cmp++; if (bus.key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_key_valid got %b want 0", bus.key_valid); end
        n_cmp++; if (bus.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err); end
        rst = 1'b0; model_reset(); clear();
        tick(40);
        n_cmp++; if (got_code.size() + got_err !== 0) begin n_bad++; $display("FAIL idle_events got %0d want 0", got_code.size() + got_err); end
    endtask

    task automatic test_single_key();
        clear();
        frame(8'h69);
        n_cmp++; if (got_code.size() !== 1) begin n_bad++; $display("FAIL single_count got %0d want 1", got_code.size()); end
        if (got_code.size() > 0) begin
            n_cmp++; if (got_code[0] !== 1) begin n_bad++; $display("FAIL single_code got %0d want 1", got_code[0]); end
            n_cmp++; if (got_cyc[0] !== last_stop_cyc + int'(FL) + 2) begin
                n_bad++; $display("FAIL single_latency got cycle %0d want %0d", got_cyc[0], last_stop_cyc + int'(FL) + 2);
            end
        end
        n_cmp++; if (got_err !== 0) begin n_bad++; $display("FAIL single_err got %0d want 0", got_err); end
    endtask

    task automatic test_typematic();
        clear();
        frame(8'h79); frame(8'h79); frame(8'h79);
        frame(8'hF0); frame(8'h79);
        frame(8'h79);
        n_cmp++; if (got_code.size() !== 2) begin n_bad++; $display("FAIL typematic_count got %0d want 2", got_code.size()); end
        foreach (got_code[i]) begin
            n_cmp++; if (got_code[i] !== 10) begin n_bad++; $display("FAIL typematic_code[%0d] got %0d want 10", i, got_code[i]); end
        end
        n_cmp++; if (bus.key_code !== 11'd10) begin n_bad++; $display("FAIL typematic_hold got %0d want 10", bus.key_code); end
    endtask

    task automatic test_extended();
        int want[3] = '{13, 14, 14};
        clear();
        frame(8'hE0); frame(8'h4A);
        frame(8'h4A);
        frame(8'hE0); frame(8'h5A);
        frame(8'hF0); frame(8'h5A);
        frame(8'h5A);
        n_cmp++; if (got_code.size() !== 3) begin n_bad++; $display("FAIL ext_count got %0d want 3", got_code.size()); end
        for (int i = 0; i < 3 && i < got_code.size(); i++) begin
            n_cmp++; if (got_code[i] !== want[i]) begin n_bad++; $display("FAIL ext_code[%0d] got %0d want %0d", i, got_code[i], want[i]); end
        end
    endtask

    task automatic test_frame_errors();
        clear();
        frame(8'h72, 1);
        n_cmp++; if (got_err !== 1 || got_code.size() !== 0) begin
            n_bad++; $display("FAIL parity_err got err=%0d keys=%0d want err=1 keys=0", got_err, got_code.size());
        end
        frame(8'h72);
        n_cmp++; if (got_code.size() !== 1 || (got_code.size() > 0 && got_code[0] !== 2)) begin
            n_bad++; $display("FAIL parity_recover got keys=%0d want one key 2", got_code.size());
        end
        frame(8'hE0); frame(8'h11, 0, 1); frame(8'h4A);
        n_cmp++; if (got_err !== 2) begin n_bad++; $display("FAIL stop_err got %0d want 2", got_err); end
        n_cmp++; if (got_code.size() !== 1) begin n_bad++; $display("FAIL prefix_cleared got keys=%0d want 1", got_code.size()); end
    endtask

    task automatic test_timeout();
        clear();
        send_frame(8'h7A, 0, 0, 5, 0);
        tick(int'(TO) + 40);
        exp_err++; m_ext = 0; m_brk = 0;
        n_cmp++; if (got_err !== 1) begin n_bad++; $display("FAIL timeout_err got %0d want 1", got_err); end
        n_cmp++; if (got_code.size() !== 0) begin n_bad++; $display("FAIL timeout_keys got %0d want 0", got_code.size()); end
        frame(8'h7A);
        n_cmp++; if (got_code.size() !== 1 || (got_code.size() > 0 && got_code[0] !== 3)) begin
            n_bad++; $display("FAIL timeout_recover got keys=%0d want one key 3", got_code.size());
        end
    endtask

    task automatic test_rst_glitch();
        int want[2] = '{3, 0};
        send_frame(8'h6B, 0, 0, 4, 0);
        rst = 1'b1; tick(3);
        n_cmp++; if (bus.key_code !== 11'd0) begin n_bad++; $display("FAIL midrst_key_code got %0d want 0", bus.key_code); end
        rst = 1'b0; model_reset(); clear();
        tick(20);
        frame(8'h7A, 0, 0, 1);
        frame(8'h70, 0, 0, 1);
        n_cmp++; if (got_code.size() !== 2 || got_err !== 0) begin
            n_bad++; $display("FAIL glitch_count got keys=%0d err=%0d want keys=2 err=0", got_code.size(), got_err);
        end
        for (int i = 0; i < 2 && i < got_code.size(); i++) begin
            n_cmp++; if (got_code[i] !== want[i]) begin n_bad++; $display("FAIL glitch_code[%0d] got %0d want %0d", i, got_code[i], want[i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [21] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D,
                                  8'h79, 8'h7B, 8'h7C, 8'h4A, 8'h5A, 8'hE0, 8'hF0, 8'hF0, 8'hE0, 8'h11, 8'h1C};
        int r;
        clear();
        for (int n = 0; n < 45; n++) begin
            r = int'($urandom_range(0, 99));
            frame(pool[$urandom_range(0, 20)], r < 6, r >= 6 && r < 10);
        end
        n_cmp++; if (got_code.size() !== exp_code.size()) begin
            n_bad++; $display("FAIL random_count got %0d want %0d", got_code.size(), exp_code.size());
        end
        for (int i = 0; i < got_code.size() && i < exp_code.size(); i++) begin
            n_cmp++; if (got_code[i] !== exp_code[i]) begin n_bad++; $display("FAIL random_code[%0d] got %0d want %0d", i, got_code[i], exp_code[i]); end
        end
        n_cmp++; if (got_err !== exp_err) begin n_bad++; $display("FAIL random_err got %0d want %0d", got_err, exp_err); end
    endtask

    task automatic test_invariants();
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL output_invariants got %0d violations want 0", viol); end
    endtask

    initial begin
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        test_reset();
        test_single_key();
        test_typematic();
        test_extended();
        test_frame_errors();
        test_timeout();
        test_rst_glitch();
        test_random();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
